// File: rtl/csc_arbiter.sv
// Two-requester round-robin front end sharing one fixed-latency RGB->YCbCr converter,
// with credit flow control and per-requester result FIFOs. Define CSC_ARBITER_STATS_EN for grant counters.
module csc_arbiter #(
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s0_valid,
  input  logic [23:0] s0_rgb,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [23:0] s1_rgb,
  output logic        s1_ready,
  output logic        conv_valid,
  output logic [7:0]  conv_red,
  output logic [7:0]  conv_green,
  output logic [7:0]  conv_blue,
  input  logic        conv_valid_in,
  input  logic [7:0]  conv_y,
  input  logic [7:0]  conv_cb,
  input  logic [7:0]  conv_cr,
  output logic        m0_valid,
  input  logic        m0_ready,
  output logic [23:0] m0_ycbcr,
  output logic        m1_valid,
  input  logic        m1_ready,
  output logic [23:0] m1_ycbcr,
`ifdef CSC_ARBITER_STATS_EN
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
`endif
  output logic        err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [1:0]    s_valid, m_ready, m_valid;
  logic [1:0]    elig, grant, push, pop, release_tag, full;
  logic [23:0]   s_rgb [2];
  logic [23:0]   m_ycbcr [2];
  logic          grant_id, accept, tail_valid, tail_id, err_set;

  logic          run_reg, last_grant_reg, conv_valid_reg, conv_id_reg, err_reg;
  logic [23:0]   conv_rgb_reg;
  logic [LATENCY-1:0] tag_valid_reg, tag_id_reg, tag_valid_next, tag_id_next;

  assign s_valid  = {s1_valid, s0_valid};
  assign m_ready  = {m1_ready, m0_ready};
  assign s_rgb[0] = s0_rgb;
  assign s_rgb[1] = s1_rgb;

  assign s0_ready = grant[0];
  assign s1_ready = grant[1];
  assign m0_valid = m_valid[0];
  assign m1_valid = m_valid[1];
  assign m0_ycbcr = m_ycbcr[0];
  assign m1_ycbcr = m_ycbcr[1];

  assign conv_valid = conv_valid_reg;
  assign {conv_red, conv_green, conv_blue} = conv_rgb_reg;
  assign err = err_reg;

  // Round-robin: on contention the requester that did not win last time goes next.
  always_comb begin
    grant_id = 1'b0;
    if (elig == 2'b11) grant_id = ~last_grant_reg;
    else               grant_id = elig[1];
  end

  assign accept = |elig;
  assign grant  = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  // conv_valid/conv_id act as the head stage; the tag register follows it so its
  // tail lines up with the converter output LATENCY cycles later.
  assign tag_valid_next[0] = conv_valid_reg;
  assign tag_id_next[0]    = conv_id_reg;
  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
    assign tag_valid_next[gi] = tag_valid_reg[gi-1];
    assign tag_id_next[gi]    = tag_id_reg[gi-1];
  end

  assign tail_valid = tag_valid_reg[LATENCY-1];
  assign tail_id    = tag_id_reg[LATENCY-1];
  assign err_set    = (conv_valid_in && (!tail_valid || full[tail_id])) ||
                      (tail_valid && !conv_valid_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
      conv_valid_reg <= 1'b0;
      conv_id_reg    <= 1'b0;
      conv_rgb_reg   <= '0;
      err_reg        <= 1'b0;
      tag_valid_reg  <= '0;
      tag_id_reg     <= '0;
    end else begin
      run_reg        <= 1'b1;
      conv_valid_reg <= accept;
      if (accept) begin
        last_grant_reg <= grant_id;
        conv_id_reg    <= grant_id;
        conv_rgb_reg   <= s_rgb[grant_id];
      end
      if (err_set) err_reg <= 1'b1;
      tag_valid_reg <= tag_valid_next;
      tag_id_reg    <= tag_id_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [23:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, inflight_reg;
    logic [CW:0]   occupancy;

    assign occupancy   = {1'b0, count_reg} + {1'b0, inflight_reg};
    assign elig[gi]    = run_reg && s_valid[gi] && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign full[gi]    = (count_reg == CW'(FIFO_DEPTH));
    assign push[gi]    = conv_valid_in && tail_valid && (tail_id == gi[0]) && !full[gi];
    // A dropped push into a full FIFO leaves inflight untouched; a missing result frees it.
    assign release_tag[gi] = tail_valid && (tail_id == gi[0]) && (!conv_valid_in || !full[gi]);
    assign m_valid[gi] = (count_reg != '0);
    assign pop[gi]     = m_valid[gi] && m_ready[gi];
    assign m_ycbcr[gi] = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
      if (push[gi]) mem[wr_ptr_reg] <= {conv_y, conv_cb, conv_cr};
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        inflight_reg <= '0;
      end else begin
        if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg    <= count_reg + CW'(push[gi]) - CW'(pop[gi]);
        inflight_reg <= inflight_reg + CW'(grant[gi]) - CW'(release_tag[gi]);
      end
    end
  end

`ifdef CSC_ARBITER_STATS_EN
  logic [15:0] grant_cnt0_reg, grant_cnt1_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0_reg <= '0;
      grant_cnt1_reg <= '0;
    end else begin
      if (grant[0]) grant_cnt0_reg <= grant_cnt0_reg + 16'd1;
      if (grant[1]) grant_cnt1_reg <= grant_cnt1_reg + 16'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_reg;
  assign grant_cnt1 = grant_cnt1_reg;
`endif

endmodule

// File: tb/tb_csc_arbiter.sv
// Scoreboard bench for csc_arbiter with a behavioural 3-cycle BT.601 converter model.
module tb_csc_arbiter;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        s0_valid = 1'b0, s1_valid = 1'b0, s0_ready, s1_ready;
  logic [23:0] s0_rgb = '0, s1_rgb = '0;
  logic        conv_valid, conv_valid_in;
  logic [7:0]  conv_red, conv_green, conv_blue, conv_y, conv_cb, conv_cr;
  logic        m0_valid, m1_valid, m0_ready = 1'b0, m1_ready = 1'b0;
  logic [23:0] m0_ycbcr, m1_ycbcr;
  logic        err;
`ifdef CSC_ARBITER_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  csc_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_valid(s0_valid), .s0_rgb(s0_rgb), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_rgb(s1_rgb), .s1_ready(s1_ready),
    .conv_valid(conv_valid), .conv_red(conv_red), .conv_green(conv_green), .conv_blue(conv_blue),
    .conv_valid_in(conv_valid_in), .conv_y(conv_y), .conv_cb(conv_cb), .conv_cr(conv_cr),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_ycbcr(m0_ycbcr),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_ycbcr(m1_ycbcr),
`ifdef CSC_ARBITER_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .err(err)
  );

  // Converter model: 10-bit fixed-point BT.601, LAT cycles valid-to-valid.
  function automatic logic [23:0] csc(input logic [23:0] rgb);
    int r, g, b, y, cb, cr;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[7:0]);
    y  = 16  + ((263 * r + 516 * g + 100 * b + 512) >>> 10);
    cb = 128 + ((-152 * r - 298 * g + 450 * b + 512) >>> 10);
    cr = 128 + ((450 * r - 377 * g - 73 * b + 512) >>> 10);
    if (y > 255) y = 255;
    if (cb > 255) cb = 255;
    if (cb < 0) cb = 0;
    if (cr > 255) cr = 255;
    if (cr < 0) cr = 0;
    return {y[7:0], cb[7:0], cr[7:0]};
  endfunction

  logic [LAT-1:0] cv_pipe;
  logic [23:0]    cd_pipe [LAT];
  logic           force_cv = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cv_pipe <= '0;
    end else begin
      cv_pipe    <= {cv_pipe[LAT-2:0], conv_valid};
      cd_pipe[0] <= csc({conv_red, conv_green, conv_blue});
      for (int k = 1; k < LAT; k++) cd_pipe[k] <= cd_pipe[k-1];
    end
  end

  assign conv_valid_in = cv_pipe[LAT-1] | force_cv;
  assign {conv_y, conv_cb, conv_cr} = cd_pipe[LAT-1];

  // Directed pixels and their hand-computed results.
  logic [23:0] pix  [5] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000};
  logic [23:0] expv [5] = '{24'h515AF0, 24'h903622, 24'h29F06E, 24'hEB8080, 24'h108080};

  int errors = 0, checks = 0;
  int cyc = 0;
  int left0 = 0, left1 = 0, idx0 = 0, idx1 = 0;
  int hs_cnt [2] = '{0, 0};
  int hs_cyc0 = 0, lat_armed = 0;
  int glog [$];
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic check_out(input int ch, input logic [23:0] act);
    logic [23:0] exp;
    checks++;
    if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL m%0d_unexpected: got %06h expected no output (cycle %0d)", ch, act, cyc);
      return;
    end
    exp = (ch == 0) ? q0.pop_front() : q1.pop_front();
    if (act !== exp) begin
      errors++;
      $display("FAIL m%0d_data: got %06h expected %06h (cycle %0d)", ch, act, exp, cyc);
    end else begin
      $display("ok   m%0d_data: %06h (cycle %0d)", ch, act, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Input driver: present the next table pixel while a send budget remains.
  always @(posedge clk) begin
    #1;
    s0_valid = reset_n && (left0 > 0);
    s1_valid = reset_n && (left1 > 0);
    s0_rgb   = pix[idx0];
    s1_rgb   = pix[idx1];
  end

  // Stimulus side pushes expectations at handshake; monitor pops on each result pop.
  always @(negedge clk) begin
    if (reset_n) begin
      if (s0_valid && s0_ready) begin
        q0.push_back(expv[idx0]);
        glog.push_back(0);
        hs_cnt[0]++;
        hs_cyc0 = cyc;
        idx0 = (idx0 + 1) % 5;
        if (left0 > 0) left0--;
      end
      if (s1_valid && s1_ready) begin
        q1.push_back(expv[idx1]);
        glog.push_back(1);
        hs_cnt[1]++;
        idx1 = (idx1 + 1) % 5;
        if (left1 > 0) left1--;
      end
      if (lat_armed != 0 && m0_valid) begin
        lat_armed = 0;
        chk("latency", 32'(cyc - hs_cyc0), 32'(LAT + 2));
      end
      if (m0_valid && m0_ready) check_out(0, m0_ycbcr);
      if (m1_valid && m1_ready) check_out(1, m1_ycbcr);
    end
  end

  task automatic wait_hs(input int ch, input int target, input int budget, input string name);
    int n = 0;
    while (hs_cnt[ch] < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(name, (hs_cnt[ch] >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(name, 32'(q0.size() + q1.size()), 32'd0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int b0, b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_conv_valid", 32'(conv_valid), 0);
    chk("rst_conv_rgb", 32'({conv_red, conv_green, conv_blue}), 0);
    chk("rst_m_valid", 32'({m1_valid, m0_valid}), 0);
    chk("rst_ready", 32'({s1_ready, s0_ready}), 0);
    chk("rst_err", 32'(err), 0);
    reset_n = 1'b1;

    // Round-robin under continuous contention, requester 0 first.
    m0_ready = 1'b1;
    m1_ready = 1'b1;
    left0 = 8;
    left1 = 8;
    wait_hs(1, 8, 100, "rr_done");
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr_grant%0d", i), 32'(glog[i]), 32'(i % 2));
    drain("rr_drain");

    // Single red pixel: latency and converted value.
    idx0 = 0;
    lat_armed = 1;
    left0 = 1;
    wait_hs(0, hs_cnt[0] + 1, 20, "single_accept");
    repeat (10) @(posedge clk);
    chk("latency_seen", 32'(lat_armed), 0);
    drain("single_drain");

    // Credit exhaustion on requester 0 while requester 1 keeps flowing.
    m0_ready = 1'b0;
    b0 = hs_cnt[0];
    b1 = hs_cnt[1];
    left0 = 100;
    left1 = 100;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("credit_s0_accepts", 32'(hs_cnt[0] - b0), 4);
    chk("credit_s1_served", (hs_cnt[1] - b1 >= 10) ? 32'd1 : 32'd0, 1);
    chk("credit_s0_ready", 32'(s0_ready), 0);
    @(posedge clk);
    #2;
    m0_ready = 1'b1;
    wait_hs(0, b0 + 6, 30, "credit_resume");
    left0 = 0;
    left1 = 0;
    drain("credit_drain");

    // Converter output with no pixel in flight.
    force_cv = 1'b1;
    @(posedge clk);
    #2;
    force_cv = 1'b0;
    @(negedge clk);
    chk("spurious_err", 32'(err), 1);
    chk("spurious_fifo", 32'({m1_valid, m0_valid}), 0);
    repeat (5) @(posedge clk);
    #2;
    chk("err_sticky", 32'(err), 1);

    // Reset with three pixels in the converter.
    b0 = hs_cnt[0];
    left0 = 3;
    wait_hs(0, b0 + 3, 20, "flight_accepts");
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_conv_valid", 32'(conv_valid), 0);
    chk("mid_rst_conv_rgb", 32'({conv_red, conv_green, conv_blue}), 0);
    chk("mid_rst_m_valid", 32'({m1_valid, m0_valid}), 0);
    chk("mid_rst_ready", 32'({s1_ready, s0_ready}), 0);
    chk("mid_rst_err", 32'(err), 0);
    q0.delete();
    q1.delete();
    left0 = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("post_rst_quiet", 32'({m1_valid, m0_valid}), 0);
    @(posedge clk);
    #2;
    m0_ready = 1'b0;
    b0 = hs_cnt[0];
    left0 = 20;
    repeat (20) @(posedge clk);
    #2;
    chk("post_rst_credits", 32'(hs_cnt[0] - b0), 4);
    left0 = 0;
    m0_ready = 1'b1;
    drain("post_rst_drain");

`ifdef CSC_ARBITER_STATS_EN
    reset_n = 1'b0;
    #2;
    q0.delete();
    q1.delete();
    reset_n = 1'b1;
    b1 = hs_cnt[1];
    left1 = 65537;
    wait_hs(1, b1 + 65537, 200000, "stats_accepts");
    drain("stats_drain");
    chk("stats_grant_cnt1", 32'(grant_cnt1), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
